// File: rtl/ocl_axil_timeout_guard.sv
// AXI4-Lite OCL guard: forwards single transactions and completes them locally with SLVERR on downstream timeout.
// Optional macro OCL_GUARD_STATS_EN builds the timeout counters and the last_to_addr capture register.
module ocl_axil_timeout_guard #(
    parameter int          ADDR_W      = 32,
    parameter int          TIMEOUT_CYC = 1024,
    parameter logic [31:0] ERR_RDATA   = 32'hDEAD_BEEF,
    parameter int          CNT_W       = 16
) (
    input  logic              clk_main_a0,
    input  logic              rst_main_n,
    input  logic [ADDR_W-1:0] s_awaddr,
    input  logic              s_awvalid,
    output logic              s_awready,
    input  logic [31:0]       s_wdata,
    input  logic [3:0]        s_wstrb,
    input  logic              s_wvalid,
    output logic              s_wready,
    output logic [1:0]        s_bresp,
    output logic              s_bvalid,
    input  logic              s_bready,
    input  logic [ADDR_W-1:0] s_araddr,
    input  logic              s_arvalid,
    output logic              s_arready,
    output logic [31:0]       s_rdata,
    output logic [1:0]        s_rresp,
    output logic              s_rvalid,
    input  logic              s_rready,
    output logic [ADDR_W-1:0] m_awaddr,
    output logic              m_awvalid,
    input  logic              m_awready,
    output logic [31:0]       m_wdata,
    output logic [3:0]        m_wstrb,
    output logic              m_wvalid,
    input  logic              m_wready,
    input  logic [1:0]        m_bresp,
    input  logic              m_bvalid,
    output logic              m_bready,
    output logic [ADDR_W-1:0] m_araddr,
    output logic              m_arvalid,
    input  logic              m_arready,
    input  logic [31:0]       m_rdata,
    input  logic [1:0]        m_rresp,
    input  logic              m_rvalid,
    output logic              m_rready,
    output logic              guard_tripped,
    output logic [CNT_W-1:0]  timeout_wr_cnt,
    output logic [CNT_W-1:0]  timeout_rd_cnt
`ifdef OCL_GUARD_STATS_EN
   ,output logic [ADDR_W-1:0] last_to_addr
`endif
);

    typedef enum logic [2:0] {W_IDLE, W_FWD, W_RESP, W_ERR, W_STALE} wst_t;
    typedef enum logic [2:0] {R_IDLE, R_FWD, R_RESP, R_ERR, R_STALE} rst_t;

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);

    // ---------------- write channel ----------------
    wst_t              r_wrst;
    logic [15:0]       r_wcnt;
    logic [ADDR_W-1:0] r_awaddr;
    logic [31:0]       r_wdata;
    logic [3:0]        r_wstrb;
    logic              r_aw_held, r_w_held, r_maw_done, r_mw_done, r_wabs;
    logic              r_s_awready, r_s_wready, r_s_bvalid, r_m_awvalid, r_m_wvalid, r_m_bready;
    logic [1:0]        r_s_bresp;

    logic w_aw_hs, w_w_hs, w_aw_h, w_w_h, w_maw_done, w_mw_done, w_mb_hs;
    logic w_wabs, w_wfire, w_wbv_n, w_aw_n, w_w_n;

    assign w_aw_hs    = s_awvalid & r_s_awready;
    assign w_w_hs     = s_wvalid & r_s_wready;
    assign w_aw_h     = r_aw_held | w_aw_hs;
    assign w_w_h      = r_w_held | w_w_hs;
    assign w_maw_done = r_maw_done | (r_m_awvalid & m_awready);
    assign w_mw_done  = r_mw_done | (r_m_wvalid & m_wready);
    assign w_mb_hs    = m_bvalid & r_m_bready;
    assign w_wabs     = r_wabs | w_mb_hs;
    assign w_wfire    = w_aw_h & w_w_h;
    assign w_wbv_n    = w_wfire | (r_s_bvalid & ~s_bready);
    assign w_aw_n     = w_aw_h & ~w_wfire;
    assign w_w_n      = w_w_h & ~w_wfire;

    always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
        if (!rst_main_n) begin
            r_wrst      <= W_IDLE;
            r_wcnt      <= '0;
            r_awaddr    <= '0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
            r_aw_held   <= 1'b0;
            r_w_held    <= 1'b0;
            r_maw_done  <= 1'b0;
            r_mw_done   <= 1'b0;
            r_wabs      <= 1'b0;
            r_s_awready <= 1'b0;
            r_s_wready  <= 1'b0;
            r_s_bvalid  <= 1'b0;
            r_s_bresp   <= 2'b00;
            r_m_awvalid <= 1'b0;
            r_m_wvalid  <= 1'b0;
            r_m_bready  <= 1'b0;
        end else begin
            // Unaccepted downstream beats persist through ERR/STALE until taken.
            r_m_awvalid <= r_m_awvalid & ~m_awready;
            r_m_wvalid  <= r_m_wvalid & ~m_wready;
            r_maw_done  <= w_maw_done;
            r_mw_done   <= w_mw_done;
            case (r_wrst)
                W_IDLE: begin
                    if (w_aw_hs) r_awaddr <= s_awaddr;
                    if (w_w_hs) begin
                        r_wdata <= s_wdata;
                        r_wstrb <= s_wstrb;
                    end
                    if (w_wfire) begin
                        r_wrst      <= W_FWD;
                        r_m_awvalid <= 1'b1;
                        r_m_wvalid  <= 1'b1;
                        r_maw_done  <= 1'b0;
                        r_mw_done   <= 1'b0;
                        r_wcnt      <= '0;
                        r_aw_held   <= 1'b0;
                        r_w_held    <= 1'b0;
                        r_s_awready <= 1'b0;
                        r_s_wready  <= 1'b0;
                    end else begin
                        r_aw_held   <= w_aw_h;
                        r_w_held    <= w_w_h;
                        r_s_awready <= ~w_aw_h;
                        r_s_wready  <= ~w_w_h;
                    end
                end
                W_FWD: begin
                    if (w_mb_hs) begin
                        r_wrst     <= W_RESP;
                        r_s_bvalid <= 1'b1;
                        r_s_bresp  <= m_bresp;
                        r_m_bready <= 1'b0;
                    end else if (r_wcnt == TO_LAST) begin
                        r_wrst     <= W_ERR;
                        r_s_bvalid <= 1'b1;
                        r_s_bresp  <= 2'b10;
                        r_m_bready <= 1'b0;
                    end else begin
                        r_wcnt     <= r_wcnt + 16'd1;
                        r_m_bready <= w_maw_done & w_mw_done;
                    end
                end
                W_RESP: begin
                    if (s_bready) begin
                        r_wrst      <= W_IDLE;
                        r_s_bvalid  <= 1'b0;
                        r_s_awready <= 1'b1;
                        r_s_wready  <= 1'b1;
                    end
                end
                W_ERR: begin
                    if (s_bready) begin
                        r_wrst      <= W_STALE;
                        r_s_bvalid  <= 1'b0;
                        r_s_awready <= 1'b1;
                        r_s_wready  <= 1'b1;
                        r_m_bready  <= w_maw_done & w_mw_done;
                        r_wabs      <= 1'b0;
                    end
                end
                W_STALE: begin
                    r_s_bvalid <= w_wbv_n;
                    if (w_wfire) r_s_bresp <= 2'b10;
                    // Once the late B is absorbed, stop taking new writes but finish any half-captured one.
                    if (w_wabs & ~w_aw_n & ~w_w_n & ~w_wbv_n) begin
                        r_wrst      <= W_IDLE;
                        r_wabs      <= 1'b0;
                        r_aw_held   <= 1'b0;
                        r_w_held    <= 1'b0;
                        r_m_bready  <= 1'b0;
                        r_s_awready <= 1'b1;
                        r_s_wready  <= 1'b1;
                    end else begin
                        r_wabs      <= w_wabs;
                        r_aw_held   <= w_aw_n;
                        r_w_held    <= w_w_n;
                        r_m_bready  <= ~w_wabs & w_maw_done & w_mw_done;
                        r_s_awready <= ~w_wbv_n & ~w_aw_n & (~w_wabs | w_w_n);
                        r_s_wready  <= ~w_wbv_n & ~w_w_n & (~w_wabs | w_aw_n);
                    end
                end
                default: r_wrst <= W_IDLE;
            endcase
        end
    end

    // ---------------- read channel ----------------
    rst_t              r_rdst;
    logic [15:0]       r_rcnt;
    logic [ADDR_W-1:0] r_araddr;
    logic              r_mar_done, r_rabs;
    logic              r_s_arready, r_s_rvalid, r_m_arvalid, r_m_rready;
    logic [31:0]       r_s_rdata;
    logic [1:0]        r_s_rresp;

    logic w_ar_hs, w_mar_done, w_mr_hs, w_rabs, w_rv_n;

    assign w_ar_hs    = s_arvalid & r_s_arready;
    assign w_mar_done = r_mar_done | (r_m_arvalid & m_arready);
    assign w_mr_hs    = m_rvalid & r_m_rready;
    assign w_rabs     = r_rabs | w_mr_hs;
    assign w_rv_n     = w_ar_hs | (r_s_rvalid & ~s_rready);

    always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
        if (!rst_main_n) begin
            r_rdst      <= R_IDLE;
            r_rcnt      <= '0;
            r_araddr    <= '0;
            r_mar_done  <= 1'b0;
            r_rabs      <= 1'b0;
            r_s_arready <= 1'b0;
            r_s_rvalid  <= 1'b0;
            r_s_rdata   <= '0;
            r_s_rresp   <= 2'b00;
            r_m_arvalid <= 1'b0;
            r_m_rready  <= 1'b0;
        end else begin
            r_m_arvalid <= r_m_arvalid & ~m_arready;
            r_mar_done  <= w_mar_done;
            case (r_rdst)
                R_IDLE: begin
                    if (w_ar_hs) begin
                        r_rdst      <= R_FWD;
                        r_araddr    <= s_araddr;
                        r_m_arvalid <= 1'b1;
                        r_mar_done  <= 1'b0;
                        r_rcnt      <= '0;
                        r_s_arready <= 1'b0;
                    end else begin
                        r_s_arready <= 1'b1;
                    end
                end
                R_FWD: begin
                    if (w_mr_hs) begin
                        r_rdst     <= R_RESP;
                        r_s_rvalid <= 1'b1;
                        r_s_rdata  <= m_rdata;
                        r_s_rresp  <= m_rresp;
                        r_m_rready <= 1'b0;
                    end else if (r_rcnt == TO_LAST) begin
                        r_rdst     <= R_ERR;
                        r_s_rvalid <= 1'b1;
                        r_s_rdata  <= ERR_RDATA;
                        r_s_rresp  <= 2'b10;
                        r_m_rready <= 1'b0;
                    end else begin
                        r_rcnt     <= r_rcnt + 16'd1;
                        r_m_rready <= w_mar_done;
                    end
                end
                R_RESP: begin
                    if (s_rready) begin
                        r_rdst      <= R_IDLE;
                        r_s_rvalid  <= 1'b0;
                        r_s_arready <= 1'b1;
                    end
                end
                R_ERR: begin
                    if (s_rready) begin
                        r_rdst      <= R_STALE;
                        r_s_rvalid  <= 1'b0;
                        r_s_arready <= 1'b1;
                        r_m_rready  <= w_mar_done;
                        r_rabs      <= 1'b0;
                    end
                end
                R_STALE: begin
                    r_s_rvalid <= w_rv_n;
                    if (w_ar_hs) begin
                        r_s_rdata <= ERR_RDATA;
                        r_s_rresp <= 2'b10;
                    end
                    if (w_rabs & ~w_rv_n) begin
                        r_rdst      <= R_IDLE;
                        r_rabs      <= 1'b0;
                        r_m_rready  <= 1'b0;
                        r_s_arready <= 1'b1;
                    end else begin
                        r_rabs      <= w_rabs;
                        r_m_rready  <= ~w_rabs & w_mar_done;
                        r_s_arready <= ~w_rv_n & ~w_rabs;
                    end
                end
                default: r_rdst <= R_IDLE;
            endcase
        end
    end

    logic r_guard;
    always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
        if (!rst_main_n) r_guard <= 1'b0;
        else             r_guard <= (r_wrst == W_STALE) | (r_rdst == R_STALE);
    end

`ifdef OCL_GUARD_STATS_EN
    logic              w_wr_to, w_rd_to;
    logic [CNT_W-1:0]  r_to_wr_cnt, r_to_rd_cnt;
    logic [ADDR_W-1:0] r_last_to_addr;

    assign w_wr_to = (r_wrst == W_FWD) & ~w_mb_hs & (r_wcnt == TO_LAST);
    assign w_rd_to = (r_rdst == R_FWD) & ~w_mr_hs & (r_rcnt == TO_LAST);

    always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
        if (!rst_main_n) begin
            r_to_wr_cnt    <= '0;
            r_to_rd_cnt    <= '0;
            r_last_to_addr <= '0;
        end else begin
            if (w_wr_to && !(&r_to_wr_cnt)) r_to_wr_cnt <= r_to_wr_cnt + CNT_W'(1);
            if (w_rd_to && !(&r_to_rd_cnt)) r_to_rd_cnt <= r_to_rd_cnt + CNT_W'(1);
            if (w_rd_to)      r_last_to_addr <= r_araddr;
            else if (w_wr_to) r_last_to_addr <= r_awaddr;
        end
    end

    assign timeout_wr_cnt = r_to_wr_cnt;
    assign timeout_rd_cnt = r_to_rd_cnt;
    assign last_to_addr   = r_last_to_addr;
`else
    assign timeout_wr_cnt = '0;
    assign timeout_rd_cnt = '0;
`endif

    assign s_awready     = r_s_awready;
    assign s_wready      = r_s_wready;
    assign s_bvalid      = r_s_bvalid;
    assign s_bresp       = r_s_bresp;
    assign s_arready     = r_s_arready;
    assign s_rvalid      = r_s_rvalid;
    assign s_rdata       = r_s_rdata;
    assign s_rresp       = r_s_rresp;
    assign m_awaddr      = r_awaddr;
    assign m_awvalid     = r_m_awvalid;
    assign m_wdata       = r_wdata;
    assign m_wstrb       = r_wstrb;
    assign m_wvalid      = r_m_wvalid;
    assign m_bready      = r_m_bready;
    assign m_araddr      = r_araddr;
    assign m_arvalid     = r_m_arvalid;
    assign m_rready      = r_m_rready;
    assign guard_tripped = r_guard;

endmodule

// File: tb/tb_ocl_axil_timeout_guard.sv
// Directed bench for ocl_axil_timeout_guard with TIMEOUT_CYC=16 and a hand-driven downstream slave.
module tb_ocl_axil_timeout_guard;

    localparam int ADDR_W = 32;
    localparam int CNT_W  = 16;
`ifdef OCL_GUARD_STATS_EN
    localparam int STATS = 1;
`else
    localparam int STATS = 0;
`endif

    logic              clk_main_a0 = 1'b0;
    logic              rst_main_n  = 1'b0;
    logic [ADDR_W-1:0] s_awaddr = '0, s_araddr = '0;
    logic              s_awvalid = 0, s_wvalid = 0, s_bready = 0, s_arvalid = 0, s_rready = 0;
    logic [31:0]       s_wdata = '0;
    logic [3:0]        s_wstrb = '0;
    logic              s_awready, s_wready, s_bvalid, s_arready, s_rvalid;
    logic [1:0]        s_bresp, s_rresp;
    logic [31:0]       s_rdata;
    logic [ADDR_W-1:0] m_awaddr, m_araddr;
    logic              m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready;
    logic [31:0]       m_wdata;
    logic [3:0]        m_wstrb;
    logic              m_awready = 1, m_wready = 1, m_bvalid = 0, m_arready = 1, m_rvalid = 0;
    logic [1:0]        m_bresp = '0, m_rresp = '0;
    logic [31:0]       m_rdata = '0;
    logic              guard_tripped;
    logic [CNT_W-1:0]  timeout_wr_cnt, timeout_rd_cnt;
`ifdef OCL_GUARD_STATS_EN
    logic [ADDR_W-1:0] last_to_addr;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    ocl_axil_timeout_guard #(.ADDR_W(ADDR_W), .TIMEOUT_CYC(16), .ERR_RDATA(32'hDEAD_BEEF), .CNT_W(CNT_W)) dut (
        .clk_main_a0(clk_main_a0), .rst_main_n(rst_main_n),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
        .guard_tripped(guard_tripped), .timeout_wr_cnt(timeout_wr_cnt), .timeout_rd_cnt(timeout_rd_cnt)
`ifdef OCL_GUARD_STATS_EN
       ,.last_to_addr(last_to_addr)
`endif
    );

    always #5 clk_main_a0 = ~clk_main_a0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_main_a0);
        #1;
    endtask

    // Returns just after the edge on which the last of AW/W was accepted.
    task automatic sh_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        logic aw_ok, w_ok;
        s_awaddr = addr; s_wdata = data; s_wstrb = strb;
        s_awvalid = 1; s_wvalid = 1;
        for (int i = 0; i < 20 && (s_awvalid || s_wvalid); i++) begin
            aw_ok = s_awready; w_ok = s_wready;
            tick();
            if (aw_ok) s_awvalid = 0;
            if (w_ok)  s_wvalid  = 0;
        end
        chk("sh_write_accepted", 64'(s_awvalid | s_wvalid), 64'(0));
        s_awvalid = 0; s_wvalid = 0;
    endtask

    task automatic sh_read(input logic [31:0] addr);
        logic ar_ok;
        s_araddr = addr; s_arvalid = 1;
        for (int i = 0; i < 20 && s_arvalid; i++) begin
            ar_ok = s_arready;
            tick();
            if (ar_ok) s_arvalid = 0;
        end
        chk("sh_read_accepted", 64'(s_arvalid), 64'(0));
        s_arvalid = 0;
    endtask

    task automatic take_b();
        s_bready = 1; tick(); s_bready = 0;
    endtask

    task automatic take_r();
        s_rready = 1; tick(); s_rready = 0;
    endtask

    initial begin
        // reset state
        #12;
        chk("rst_s_awready", 64'(s_awready), 64'(0));
        chk("rst_valids", 64'({m_awvalid, m_wvalid, m_arvalid, s_bvalid, s_rvalid, m_bready, m_rready}), 64'(0));
        chk("rst_rdata", 64'({s_rdata, s_bresp, s_rresp}), 64'(0));
        chk("rst_cnts", 64'({timeout_wr_cnt, timeout_rd_cnt, guard_tripped}), 64'(0));
        @(negedge clk_main_a0);
        rst_main_n = 1;
        tick();
        chk("idle_ready", 64'({s_awready, s_wready, s_arready}), 64'(3'b111));

        // 1: plain write, B three cycles after downstream W handshake
        sh_write(32'h10, 32'h1234_5678, 4'hF);
        chk("t1_m_awvalid", 64'({m_awvalid, m_wvalid, m_bready}), 64'(3'b110));
        chk("t1_m_awaddr", 64'(m_awaddr), 64'(32'h10));
        chk("t1_m_wdata", 64'(m_wdata), 64'(32'h1234_5678));
        tick();
        chk("t1_after_hs", 64'({m_awvalid, m_wvalid, m_bready}), 64'(3'b001));
        tick(); tick(); tick();
        chk("t1_bvalid_early", 64'(s_bvalid), 64'(0));
        m_bvalid = 1; m_bresp = 2'b00;
        tick();
        m_bvalid = 0;
        chk("t1_bvalid_at5", 64'(s_bvalid), 64'(1));
        chk("t1_bresp", 64'(s_bresp), 64'(2'b00));
        chk("t1_guard", 64'(guard_tripped), 64'(0));
        take_b();
        chk("t1_bvalid_drop", 64'(s_bvalid), 64'(0));

        // 2: W arrives 4 cycles ahead of AW
        m_awready = 0; m_wready = 0;
        s_wdata = 32'hCAFE_F00D; s_wstrb = 4'b0101; s_wvalid = 1;
        tick();
        s_wvalid = 0;
        chk("t2_wready_low", 64'(s_wready), 64'(0));
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t2_no_fwd", 64'({m_awvalid, m_wvalid}), 64'(0));
        end
        chk("t2_awready", 64'(s_awready), 64'(1));
        s_awaddr = 32'h24; s_awvalid = 1;
        tick();
        s_awvalid = 0;
        chk("t2_fwd", 64'({m_awvalid, m_wvalid}), 64'(2'b11));
        chk("t2_addr", 64'(m_awaddr), 64'(32'h24));
        chk("t2_data", 64'({m_wdata, m_wstrb}), 64'({32'hCAFE_F00D, 4'b0101}));
        m_awready = 1;
        tick();
        chk("t2_aw_only", 64'({m_awvalid, m_wvalid, m_bready}), 64'(3'b010));
        m_wready = 1;
        tick();
        chk("t2_w_done", 64'({m_awvalid, m_wvalid, m_bready}), 64'(3'b001));
        m_bvalid = 1; m_bresp = 2'b00;
        tick();
        m_bvalid = 0;
        chk("t2_bresp", 64'({s_bvalid, s_bresp}), 64'(3'b100));
        take_b();

        // 3: read timeout
        sh_read(32'h40);
        for (int i = 1; i <= 16; i++) begin
            tick();
            if (i == 1)  chk("t3_ar_taken", 64'({m_arvalid, m_rready}), 64'(2'b01));
            if (i == 15) chk("t3_rvalid_early", 64'(s_rvalid), 64'(0));
        end
        chk("t3_rvalid", 64'(s_rvalid), 64'(1));
        chk("t3_rdata", 64'(s_rdata), 64'(32'hDEAD_BEEF));
        chk("t3_rresp", 64'(s_rresp), 64'(2'b10));
        chk("t3_rd_cnt", 64'(timeout_rd_cnt), 64'(STATS));
        take_r();
        tick();
        chk("t3_guard", 64'(guard_tripped), 64'(1));
        chk("t3_stale_rready", 64'(m_rready), 64'(1));
`ifdef OCL_GUARD_STATS_EN
        chk("t3_last_addr", 64'(last_to_addr), 64'(32'h40));
`endif

        // 4: read while stale, then late R absorbed
        sh_read(32'h80);
        chk("t4_local_r", 64'({s_rvalid, s_rresp}), 64'(3'b110));
        chk("t4_local_data", 64'(s_rdata), 64'(32'hDEAD_BEEF));
        chk("t4_no_fwd", 64'(m_arvalid), 64'(0));
        take_r();
        m_rvalid = 1; m_rdata = 32'h1111_2222; m_rresp = 2'b00;
        tick();
        m_rvalid = 0;
        chk("t4_absorbed", 64'(s_rvalid), 64'(0));
        tick();
        chk("t4_guard_clr", 64'(guard_tripped), 64'(0));
        chk("t4_idle", 64'({s_arready, m_rready}), 64'(2'b10));

        // 5: B lands on the last allowed cycle
        sh_write(32'h30, 32'hA5A5_A5A5, 4'hF);
        for (int i = 1; i <= 15; i++) tick();
        chk("t5_bvalid_early", 64'(s_bvalid), 64'(0));
        m_bvalid = 1; m_bresp = 2'b11;
        tick();
        m_bvalid = 0;
        chk("t5_real_bresp", 64'({s_bvalid, s_bresp}), 64'(3'b111));
        chk("t5_wr_cnt", 64'(timeout_wr_cnt), 64'(0));
        take_b();

        // 5b: write timeout, local SLVERR while stale, late B absorbed
        sh_write(32'h50, 32'h0BAD_F00D, 4'hF);
        for (int i = 1; i <= 16; i++) tick();
        chk("t5b_err", 64'({s_bvalid, s_bresp}), 64'(3'b110));
        chk("t5b_wr_cnt", 64'(timeout_wr_cnt), 64'(STATS));
`ifdef OCL_GUARD_STATS_EN
        chk("t5b_last_addr", 64'(last_to_addr), 64'(32'h50));
`endif
        take_b();
        tick();
        chk("t5b_guard", 64'(guard_tripped), 64'(1));
        sh_write(32'h60, 32'h7777_7777, 4'hF);
        chk("t5b_local_b", 64'({s_bvalid, s_bresp}), 64'(3'b110));
        chk("t5b_no_fwd", 64'({m_awvalid, m_wvalid}), 64'(0));
        take_b();
        m_bvalid = 1; m_bresp = 2'b00;
        tick();
        m_bvalid = 0;
        tick();
        chk("t5b_absorbed", 64'({s_bvalid, guard_tripped}), 64'(0));

        // 6: reset mid-forward
        m_awready = 0; m_wready = 0;
        sh_write(32'h70, 32'h5555_AAAA, 4'h3);
        chk("t6_fwd", 64'({m_awvalid, m_wvalid}), 64'(2'b11));
        #2 rst_main_n = 0;
        #1;
        chk("t6_async_drop", 64'({m_awvalid, m_wvalid, s_bvalid}), 64'(0));
        tick(); tick();
        rst_main_n = 1;
        m_awready = 1; m_wready = 1;
        tick();
        sh_write(32'h74, 32'h0000_0001, 4'hF);
        tick();
        m_bvalid = 1; m_bresp = 2'b00;
        tick();
        m_bvalid = 0;
        chk("t6_write_ok", 64'({s_bvalid, s_bresp}), 64'(3'b100));
        chk("t6_cnts", 64'({timeout_wr_cnt, timeout_rd_cnt}), 64'(0));
`ifdef OCL_GUARD_STATS_EN
        chk("t6_last_addr", 64'(last_to_addr), 64'(0));
`endif
        take_b();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
